// File: rtl/osc_cmd_pkg.sv
// osc_cmd_pkg: shared constants and state encoding for the oscilloscope command controller
package osc_cmd_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ADDR_TRIG = 8'd0;
  localparam logic [7:0] ADDR_TB = 8'd1;
  localparam logic [7:0] ADDR_CTRL = 8'd2;
  localparam logic [7:0] ADDR_ARM = 8'd3;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_CHK} state_t;
endpackage

// File: rtl/osc_cmd_ctrl_gap_timer.sv
// gap_timer: inter-byte timeout counter, EXPIRED while the count sits at TIMEOUT_CYC-1
// Ports: CLK clock, RST sync reset, CLR clear count, EN count enable, EXPIRED timeout reached
module gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);
  localparam int W = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge CLK)
    r_cnt <= RST || CLR ? '0 : EN && !EXPIRED ? r_cnt + W'(1) : r_cnt;
  assign EXPIRED = r_cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/osc_cmd_ctrl.sv
// osc_cmd_ctrl: frames 4-byte command packets (SYNC, ADDR, DATA, CHK) into scope config register writes
// Ports: CLK/RST sync active-high; BYTE_IN/BYTE_RDY received byte strobe;
//        TRIG_LEVEL, TIMEBASE, RUN, TRIG_EDGE config outputs; ARM_PULSE, CMD_OK, CMD_ERR one-cycle pulses;
//        ERR_CODE cause of last error (1 checksum, 2 bad address, 3 timeout)
module osc_cmd_ctrl
  import osc_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0] TRIG_RST    = 8'h80
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_RDY,
  output logic [7:0] TRIG_LEVEL,
  output logic [7:0] TIMEBASE,
  output logic       RUN,
  output logic       TRIG_EDGE,
  output logic       ARM_PULSE,
  output logic       CMD_OK,
  output logic       CMD_ERR,
  output logic [1:0] ERR_CODE
);
  state_t     r_state, w_next;
  logic [7:0] r_addr, r_data, r_trig, r_tb;
  logic       r_run, r_edge, r_arm, r_ok, r_err;
  logic [1:0] r_code, w_code;
  logic       w_expired, w_timeout, w_eval, w_ok, w_err;
  gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .CLK(CLK),
    .RST(RST),
    .CLR(BYTE_RDY || r_state == S_IDLE),
    .EN(r_state != S_IDLE),
    .EXPIRED(w_expired)
  );
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout = w_expired && !BYTE_RDY && r_state != S_IDLE;
  always_ff @(posedge CLK)
    r_state <= RST ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = S_IDLE;
    else if (BYTE_RDY)
      w_next = r_state == S_IDLE     ? (BYTE_IN == SYNC_BYTE ? S_GET_ADDR : S_IDLE) :
               r_state == S_GET_ADDR ? S_GET_DATA :
               r_state == S_GET_DATA ? S_GET_CHK  : S_IDLE;
  end
  // Checksum is judged before the address range.
  always_comb begin
    w_eval = BYTE_RDY && r_state == S_GET_CHK;
    w_ok   = w_eval && BYTE_IN == 8'(r_addr + r_data) && r_addr <= ADDR_ARM;
    w_err  = (w_eval && !w_ok) || w_timeout;
    w_code = w_timeout ? ERR_TIMEOUT : BYTE_IN != 8'(r_addr + r_data) ? ERR_CHK : ERR_ADDR;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr <= '0;
      r_data <= '0;
      r_trig <= TRIG_RST;
      r_tb   <= '0;
      r_run  <= 1'b0;
      r_edge <= 1'b0;
      r_arm  <= 1'b0;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
      r_code <= ERR_NONE;
    end else begin
      if (BYTE_RDY && r_state == S_GET_ADDR) r_addr <= BYTE_IN;
      if (BYTE_RDY && r_state == S_GET_DATA) r_data <= BYTE_IN;
      r_ok  <= w_ok;
      r_err <= w_err;
      r_arm <= w_ok && r_addr == ADDR_ARM;
      if (w_err) r_code <= w_code;
      if (w_ok && r_addr == ADDR_TRIG) r_trig <= r_data;
      if (w_ok && r_addr == ADDR_TB) r_tb <= r_data;
      if (w_ok && r_addr == ADDR_CTRL) {r_edge, r_run} <= r_data[1:0];
    end
  end
  assign TRIG_LEVEL = r_trig;
  assign TIMEBASE   = r_tb;
  assign RUN        = r_run;
  assign TRIG_EDGE  = r_edge;
  assign ARM_PULSE  = r_arm;
  assign CMD_OK     = r_ok;
  assign CMD_ERR    = r_err;
  assign ERR_CODE   = r_code;
endmodule
